// File: rtl/data_memory_hs.sv
// ---------------------------------------------------------------------------
// data_memory_hs
//   Handshaked single-port data memory with independently configurable read
//   and write latencies (wait-state model) and out-of-range error reporting.
//
//   Optional build macro: DMEM_BYTE_LANE_EN
//     defined   : req_be port exists; writes update only enabled byte lanes
//     undefined : no req_be port; every write updates the full word
//
// Ports
//   clk        clock, all state updates on rising edge
//   rst_n      synchronous reset, active-low (memory contents are kept)
//   req_valid  request present
//   req_ready  block can accept a request this cycle
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte-lane write enables (DMEM_BYTE_LANE_EN only)
//   rsp_valid  one-cycle response / write-ack pulse
//   rsp_rdata  read data, 0 for writes and errors, held between responses
//   rsp_err    address >= DEPTH, qualified by rsp_valid, held between responses
//   busy       transaction in flight
// ---------------------------------------------------------------------------
module data_memory_hs #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
  localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                ready_r, rsp_valid_r, rsp_err_r, busy_r;
  logic [DATA_W-1:0]   rsp_rdata_r;

  // request fields captured at accept
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [NB-1:0]       be_r;

  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                accept_s;
  logic [3:0]          lat_s;
  logic [NB-1:0]       req_be_s;
  logic                go_resp_s;
  logic                txn_we_s;
  logic [ADDR_W-1:0]   txn_addr_s;
  logic [DATA_W-1:0]   txn_wdata_s;
  logic [NB-1:0]       txn_be_s;
  logic                txn_inrange_s;
  logic [IDX_W-1:0]    txn_idx_s;

`ifdef DMEM_BYTE_LANE_EN
  assign req_be_s = req_be;
`else
  assign req_be_s = {NB{1'b1}};
`endif

  // Transaction completing this edge: a latched one leaving WAIT, or a
  // latency-1 request being accepted right now.
  always_comb begin
    accept_s = req_valid && ready_r;
    lat_s    = req_we ? WR_LAT_C : RD_LAT_C;
    if (state_r == WAIT) begin
      txn_we_s    = we_r;
      txn_addr_s  = addr_r;
      txn_wdata_s = wdata_r;
      txn_be_s    = be_r;
    end else begin
      txn_we_s    = req_we;
      txn_addr_s  = req_addr;
      txn_wdata_s = req_wdata;
      txn_be_s    = req_be_s;
    end
    // full-width compare so high address bits never alias into the array
    txn_inrange_s = (txn_addr_s < DEPTH_A);
    txn_idx_s     = txn_addr_s[IDX_W-1:0];
  end

  // Next-state and latency counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept_s) begin
          cnt_s   = lat_s - 4'd1;
          state_s = (lat_s > 4'd1) ? WAIT : RESP;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
    go_resp_s = (state_s == RESP);
  end

  // FSM state, handshake outputs and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ready_r     <= (state_s != WAIT);
      rsp_valid_r <= go_resp_s;
      busy_r      <= (state_s != IDLE);
      if (go_resp_s) begin
        rsp_err_r   <= !txn_inrange_s;
        rsp_rdata_r <= (!txn_we_s && txn_inrange_s) ? mem_r[txn_idx_s] : {DATA_W{1'b0}};
      end
    end
  end

  // Capture request fields on accept for multi-cycle transactions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= {NB{1'b0}};
    end else if (accept_s) begin
      we_r    <= req_we;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      be_r    <= req_be_s;
    end
  end

  // Write commit on the edge that raises the ack; no reset so contents survive.
  always_ff @(posedge clk) begin
    if (rst_n && go_resp_s && txn_we_s && txn_inrange_s) begin
      for (int i = 0; i < NB; i++) begin
        if (txn_be_s[i]) begin
          mem_r[txn_idx_s][i*8 +: 8] <= txn_wdata_s[i*8 +: 8];
        end
      end
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;

endmodule
